// File: rtl/dmem_bridge_if.sv
// Core-side memory port plus bus-side request/ack signals of the data-memory bridge.
// The master modport is the bridge's view; slave is the core/bus environment.
interface dmem_bridge_if;
    logic        i_valid;
    logic [29:0] i_mem_addr;
    logic [31:0] i_mem_data;
    logic        i_mem_we;
    logic [3:0]  i_mem_mask;
    logic [31:0] o_mem_data;
    logic        o_stall;

    logic        o_bus_req;
    logic [29:0] o_bus_addr;
    logic [31:0] o_bus_wdata;
    logic        o_bus_we;
    logic [3:0]  o_bus_mask;
    logic        i_bus_ack;
    logic [31:0] i_bus_rdata;
    logic        o_err;

    modport master (
        input  i_valid, i_mem_addr, i_mem_data, i_mem_we, i_mem_mask,
        input  i_bus_ack, i_bus_rdata,
        output o_mem_data, o_stall, o_bus_req, o_bus_addr, o_bus_wdata,
        output o_bus_we, o_bus_mask, o_err
    );

    modport slave (
        output i_valid, i_mem_addr, i_mem_data, i_mem_we, i_mem_mask,
        output i_bus_ack, i_bus_rdata,
        input  o_mem_data, o_stall, o_bus_req, o_bus_addr, o_bus_wdata,
        input  o_bus_we, o_bus_mask, o_err
    );
endinterface

// File: rtl/dmem_bridge.sv
// Data-memory bridge: latches one core access, runs a req/ack bus handshake with a
// programmable timeout, stalls the core meanwhile and holds load data afterwards.
module dmem_bridge #(
    parameter logic [15:0] TIMEOUT = 16'd255
) (
    input  logic              clk,
    input  logic              rst,
    dmem_bridge_if.master     mem
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        BUS  = 2'd1,
        DONE = 2'd2
    } state_e;

    state_e      state_q, state_d;
    logic [29:0] addr_q,  addr_d;
    logic [31:0] wdata_q, wdata_d;
    logic        we_q,    we_d;
    logic [3:0]  mask_q,  mask_d;
    logic [31:0] rdata_q, rdata_d;
    logic        err_q,   err_d;
    logic [15:0] cnt_q,   cnt_d;
    logic        timeout_hit;

    // Abort on the TIMEOUT-th bus cycle without ack; the counter holds cycles already waited.
    assign timeout_hit = (TIMEOUT != 16'd0) && (cnt_q == TIMEOUT - 16'd1);

    // NOTE: sequential state uses non-blocking assignments so every register samples
    // the pre-edge values, independent of statement order.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
            addr_q  <= '0;
            wdata_q <= '0;
            we_q    <= 1'b0;
            mask_q  <= '0;
            rdata_q <= '0;
            err_q   <= 1'b0;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            addr_q  <= addr_d;
            wdata_q <= wdata_d;
            we_q    <= we_d;
            mask_q  <= mask_d;
            rdata_q <= rdata_d;
            err_q   <= err_d;
            cnt_q   <= cnt_d;
        end
    end

    // NOTE: every signal gets a hold-value default first, so no path through the
    // case statement can leave it unassigned and infer a latch.
    always_comb begin
        state_d = state_q;
        addr_d  = addr_q;
        wdata_d = wdata_q;
        we_d    = we_q;
        mask_d  = mask_q;
        rdata_d = rdata_q;
        err_d   = err_q;
        cnt_d   = cnt_q;

        unique case (state_q)
            IDLE: begin
                if (mem.i_valid) begin
                    addr_d  = mem.i_mem_addr;
                    wdata_d = mem.i_mem_data;
                    we_d    = mem.i_mem_we;
                    mask_d  = mem.i_mem_mask;
                    cnt_d   = '0;
                    state_d = BUS;
                end
            end
            BUS: begin
                if (mem.i_bus_ack) begin
                    if (!we_q) rdata_d = mem.i_bus_rdata;
                    state_d = DONE;
                end else if (timeout_hit) begin
                    err_d = 1'b1;
                    if (!we_q) rdata_d = '0;
                    state_d = DONE;
                end else if (cnt_q != 16'hFFFF) begin
                    cnt_d = cnt_q + 16'd1;
                end
            end
            // The core still shows the retiring access here, so i_valid is ignored.
            DONE:    state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_comb begin
        mem.o_bus_req   = (state_q == BUS);
        mem.o_stall     = ((state_q == IDLE) && mem.i_valid) || (state_q == BUS);
        mem.o_bus_addr  = addr_q;
        mem.o_bus_wdata = wdata_q;
        mem.o_bus_we    = we_q;
        mem.o_bus_mask  = mask_q;
        mem.o_mem_data  = rdata_q;
        mem.o_err       = err_q;
    end

endmodule

// File: tb/tb_dmem_bridge.sv
// Directed bench for dmem_bridge: one instance at the default timeout, one at TIMEOUT=4.
module tb_dmem_bridge;

    logic clk = 1'b0;
    logic rst = 1'b1;
    int   total = 0;
    int   bad   = 0;

    dmem_bridge_if bus_a ();
    dmem_bridge_if bus_b ();

    dmem_bridge u_dut (
        .clk (clk),
        .rst (rst),
        .mem (bus_a)
    );

    dmem_bridge #(.TIMEOUT(16'd4)) u_dut_to (
        .clk (clk),
        .rst (rst),
        .mem (bus_b)
    );

    always #5 clk = ~clk;

    // Inputs change 1ns after the rising edge; outputs are sampled 1ns later.
    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic idle_inputs;
        bus_a.i_valid = 0; bus_a.i_mem_addr = '0; bus_a.i_mem_data = '0;
        bus_a.i_mem_we = 0; bus_a.i_mem_mask = '0; bus_a.i_bus_ack = 0; bus_a.i_bus_rdata = '0;
        bus_b.i_valid = 0; bus_b.i_mem_addr = '0; bus_b.i_mem_data = '0;
        bus_b.i_mem_we = 0; bus_b.i_mem_mask = '0; bus_b.i_bus_ack = 0; bus_b.i_bus_rdata = '0;
    endtask

    task automatic test_reset;
        rst = 1;
        tick; tick;
        rst = 0;
        #1;
        total++; if ({bus_a.o_bus_req, bus_a.o_stall, bus_a.o_err} !== 3'b000) begin
            bad++; $display("FAIL reset_ctrl_a got=%b exp=000", {bus_a.o_bus_req, bus_a.o_stall, bus_a.o_err}); end
        total++; if ({bus_a.o_bus_addr, bus_a.o_bus_wdata, bus_a.o_bus_we, bus_a.o_bus_mask} !== 67'd0) begin
            bad++; $display("FAIL reset_bus_regs_a got=%h exp=0", {bus_a.o_bus_addr, bus_a.o_bus_wdata, bus_a.o_bus_we, bus_a.o_bus_mask}); end
        total++; if (bus_a.o_mem_data !== 32'h0) begin
            bad++; $display("FAIL reset_mem_data_a got=%h exp=0", bus_a.o_mem_data); end
        total++; if ({bus_b.o_bus_req, bus_b.o_stall, bus_b.o_err} !== 3'b000) begin
            bad++; $display("FAIL reset_ctrl_b got=%b exp=000", {bus_b.o_bus_req, bus_b.o_stall, bus_b.o_err}); end
        bus_a.i_valid = 1; #1;
        total++; if (bus_a.o_stall !== 1'b1) begin
            bad++; $display("FAIL reset_stall_comb got=%b exp=1", bus_a.o_stall); end
        bus_a.i_valid = 0; #1;
    endtask

    task automatic test_load_immediate;
        int reqs = 0;
        bus_a.i_valid = 1; bus_a.i_mem_we = 0; bus_a.i_mem_addr = 30'h10; bus_a.i_mem_mask = 4'hF;
        #1; reqs += int'(bus_a.o_bus_req);
        total++; if ({bus_a.o_stall, bus_a.o_bus_req} !== 2'b10) begin
            bad++; $display("FAIL load_accept got=%b exp=10", {bus_a.o_stall, bus_a.o_bus_req}); end
        tick;
        bus_a.i_bus_ack = 1; bus_a.i_bus_rdata = 32'hCAFE_F00D;
        #1; reqs += int'(bus_a.o_bus_req);
        total++; if ({bus_a.o_stall, bus_a.o_bus_req, bus_a.o_bus_addr} !== {2'b11, 30'h10}) begin
            bad++; $display("FAIL load_bus got=%h exp=%h", {bus_a.o_stall, bus_a.o_bus_req, bus_a.o_bus_addr}, {2'b11, 30'h10}); end
        tick;
        bus_a.i_bus_ack = 0; bus_a.i_bus_rdata = '0;
        #1; reqs += int'(bus_a.o_bus_req);
        total++; if (bus_a.o_stall !== 1'b0) begin
            bad++; $display("FAIL load_done_stall got=%b exp=0", bus_a.o_stall); end
        total++; if (bus_a.o_mem_data !== 32'hCAFE_F00D) begin
            bad++; $display("FAIL load_done_data got=%h exp=cafef00d", bus_a.o_mem_data); end
        tick;
        bus_a.i_valid = 0;
        #1; reqs += int'(bus_a.o_bus_req);
        total++; if (bus_a.o_mem_data !== 32'hCAFE_F00D) begin
            bad++; $display("FAIL load_hold_data got=%h exp=cafef00d", bus_a.o_mem_data); end
        total++; if (reqs != 1) begin
            bad++; $display("FAIL load_req_cycles got=%0d exp=1", reqs); end
    endtask

    task automatic test_store_slow;
        int stalls = 0;
        bus_a.i_valid = 1; bus_a.i_mem_we = 1; bus_a.i_mem_addr = 30'h2AB;
        bus_a.i_mem_data = 32'h1234_5678; bus_a.i_mem_mask = 4'b0011;
        #1; stalls += int'(bus_a.o_stall);
        for (int i = 1; i <= 6; i++) begin
            tick;
            // Perturb the core inputs to prove the bus side uses the latched copy.
            bus_a.i_mem_addr = 30'h3FFF_FFFF; bus_a.i_mem_data = 32'hFFFF_FFFF;
            bus_a.i_mem_we = 0; bus_a.i_mem_mask = 4'hC;
            bus_a.i_bus_ack = (i == 6); bus_a.i_bus_rdata = 32'hDEAD_BEEF;
            #1; stalls += int'(bus_a.o_stall);
            total++; if ({bus_a.o_bus_req, bus_a.o_bus_addr, bus_a.o_bus_wdata, bus_a.o_bus_we, bus_a.o_bus_mask}
                         !== {1'b1, 30'h2AB, 32'h1234_5678, 1'b1, 4'b0011}) begin
                bad++; $display("FAIL store_bus_cycle%0d got=%h exp=%h", i,
                    {bus_a.o_bus_req, bus_a.o_bus_addr, bus_a.o_bus_wdata, bus_a.o_bus_we, bus_a.o_bus_mask},
                    {1'b1, 30'h2AB, 32'h1234_5678, 1'b1, 4'b0011}); end
        end
        tick;
        bus_a.i_bus_ack = 0; bus_a.i_bus_rdata = '0;
        #1; stalls += int'(bus_a.o_stall);
        total++; if ({bus_a.o_stall, bus_a.o_bus_req} !== 2'b00) begin
            bad++; $display("FAIL store_done got=%b exp=00", {bus_a.o_stall, bus_a.o_bus_req}); end
        total++; if (bus_a.o_mem_data !== 32'hCAFE_F00D) begin
            bad++; $display("FAIL store_mem_data got=%h exp=cafef00d", bus_a.o_mem_data); end
        total++; if (stalls != 7) begin
            bad++; $display("FAIL store_stall_cycles got=%0d exp=7", stalls); end
        tick;
        idle_inputs();
    endtask

    task automatic test_zero_mask_store;
        bus_a.i_valid = 1; bus_a.i_mem_we = 1; bus_a.i_mem_addr = 30'h5;
        bus_a.i_mem_data = 32'hFFFF_0000; bus_a.i_mem_mask = 4'b0000;
        tick;
        bus_a.i_bus_ack = 1;
        #1;
        total++; if ({bus_a.o_bus_req, bus_a.o_bus_we, bus_a.o_bus_mask, bus_a.o_bus_addr} !== {2'b11, 4'b0000, 30'h5}) begin
            bad++; $display("FAIL zmask_issued got=%h exp=%h",
                {bus_a.o_bus_req, bus_a.o_bus_we, bus_a.o_bus_mask, bus_a.o_bus_addr}, {2'b11, 4'b0000, 30'h5}); end
        tick;
        idle_inputs();
        tick;
    endtask

    task automatic test_ack_on_timeout;
        bus_b.i_valid = 1; bus_b.i_mem_we = 0; bus_b.i_mem_addr = 30'h7; bus_b.i_mem_mask = 4'hF;
        for (int i = 1; i <= 4; i++) begin
            tick;
            bus_b.i_bus_ack = (i == 4); bus_b.i_bus_rdata = 32'hA5A5_A5A5;
            #1;
            total++; if (bus_b.o_bus_req !== 1'b1) begin
                bad++; $display("FAIL ackto_req_cycle%0d got=%b exp=1", i, bus_b.o_bus_req); end
        end
        tick;
        bus_b.i_bus_ack = 0; bus_b.i_valid = 0;
        #1;
        total++; if ({bus_b.o_err, bus_b.o_stall, bus_b.o_bus_req} !== 3'b000) begin
            bad++; $display("FAIL ackto_done_ctrl got=%b exp=000", {bus_b.o_err, bus_b.o_stall, bus_b.o_bus_req}); end
        total++; if (bus_b.o_mem_data !== 32'hA5A5_A5A5) begin
            bad++; $display("FAIL ackto_data got=%h exp=a5a5a5a5", bus_b.o_mem_data); end
        tick;
    endtask

    task automatic test_timeout;
        int reqs = 0;
        bus_b.i_valid = 1; bus_b.i_mem_we = 0; bus_b.i_mem_addr = 30'h8;
        for (int i = 1; i <= 4; i++) begin
            tick;
            #1; reqs += int'(bus_b.o_bus_req);
        end
        tick;
        bus_b.i_valid = 0;
        #1;
        total++; if (reqs != 4) begin
            bad++; $display("FAIL timeout_req_cycles got=%0d exp=4", reqs); end
        total++; if ({bus_b.o_err, bus_b.o_stall, bus_b.o_bus_req} !== 3'b100) begin
            bad++; $display("FAIL timeout_done_ctrl got=%b exp=100", {bus_b.o_err, bus_b.o_stall, bus_b.o_bus_req}); end
        total++; if (bus_b.o_mem_data !== 32'h0) begin
            bad++; $display("FAIL timeout_data got=%h exp=0", bus_b.o_mem_data); end
        tick;
        bus_b.i_bus_ack = 1; bus_b.i_bus_rdata = 32'hBAD0_BAD0;
        tick;
        bus_b.i_bus_ack = 0;
        #1;
        total++; if ({bus_b.o_err, bus_b.o_stall, bus_b.o_bus_req, bus_b.o_mem_data} !== {3'b100, 32'h0}) begin
            bad++; $display("FAIL timeout_stray_ack got=%h exp=%h",
                {bus_b.o_err, bus_b.o_stall, bus_b.o_bus_req, bus_b.o_mem_data}, {3'b100, 32'h0}); end
        bus_b.i_valid = 1; bus_b.i_mem_addr = 30'h9;
        tick;
        bus_b.i_bus_ack = 1; bus_b.i_bus_rdata = 32'h1111_2222;
        tick;
        bus_b.i_bus_ack = 0; bus_b.i_valid = 0;
        #1;
        total++; if ({bus_b.o_err, bus_b.o_mem_data} !== {1'b1, 32'h1111_2222}) begin
            bad++; $display("FAIL timeout_err_sticky got=%h exp=%h", {bus_b.o_err, bus_b.o_mem_data}, {1'b1, 32'h1111_2222}); end
        tick;
    endtask

    task automatic test_back_to_back;
        int reqs = 0;
        bus_a.i_valid = 1; bus_a.i_mem_we = 0; bus_a.i_mem_addr = 30'h20; bus_a.i_mem_mask = 4'hF;
        #1; reqs += int'(bus_a.o_bus_req);
        tick;
        bus_a.i_bus_ack = 1; bus_a.i_bus_rdata = 32'h0000_0001;
        #1; reqs += int'(bus_a.o_bus_req);
        tick;
        bus_a.i_bus_ack = 0;
        #1; reqs += int'(bus_a.o_bus_req);
        total++; if ({bus_a.o_bus_req, bus_a.o_stall, bus_a.o_mem_data} !== {2'b00, 32'h1}) begin
            bad++; $display("FAIL b2b_done1 got=%h exp=%h", {bus_a.o_bus_req, bus_a.o_stall, bus_a.o_mem_data}, {2'b00, 32'h1}); end
        tick;
        bus_a.i_mem_addr = 30'h21;
        #1; reqs += int'(bus_a.o_bus_req);
        total++; if ({bus_a.o_bus_req, bus_a.o_stall} !== 2'b01) begin
            bad++; $display("FAIL b2b_accept2 got=%b exp=01", {bus_a.o_bus_req, bus_a.o_stall}); end
        tick;
        bus_a.i_bus_ack = 1; bus_a.i_bus_rdata = 32'h0000_0002;
        #1; reqs += int'(bus_a.o_bus_req);
        total++; if ({bus_a.o_bus_req, bus_a.o_bus_addr} !== {1'b1, 30'h21}) begin
            bad++; $display("FAIL b2b_bus2 got=%h exp=%h", {bus_a.o_bus_req, bus_a.o_bus_addr}, {1'b1, 30'h21}); end
        tick;
        bus_a.i_bus_ack = 0; bus_a.i_valid = 0;
        #1; reqs += int'(bus_a.o_bus_req);
        total++; if (bus_a.o_mem_data !== 32'h2) begin
            bad++; $display("FAIL b2b_data2 got=%h exp=2", bus_a.o_mem_data); end
        tick;
        #1; reqs += int'(bus_a.o_bus_req);
        total++; if (reqs != 2) begin
            bad++; $display("FAIL b2b_req_cycles got=%0d exp=2", reqs); end
    endtask

    task automatic test_reset_mid;
        bus_a.i_valid = 1; bus_a.i_mem_we = 1; bus_a.i_mem_addr = 30'h33;
        bus_a.i_mem_data = 32'h77; bus_a.i_mem_mask = 4'hF;
        tick;
        #1;
        total++; if (bus_a.o_bus_req !== 1'b1) begin
            bad++; $display("FAIL rstmid_bus1 got=%b exp=1", bus_a.o_bus_req); end
        tick;
        rst = 1;
        tick;
        rst = 0; bus_a.i_valid = 0;
        #1;
        total++; if ({bus_a.o_bus_req, bus_a.o_stall, bus_a.o_err} !== 3'b000) begin
            bad++; $display("FAIL rstmid_ctrl got=%b exp=000", {bus_a.o_bus_req, bus_a.o_stall, bus_a.o_err}); end
        total++; if ({bus_a.o_bus_addr, bus_a.o_bus_wdata, bus_a.o_bus_we, bus_a.o_bus_mask, bus_a.o_mem_data} !== 99'd0) begin
            bad++; $display("FAIL rstmid_regs got=%h exp=0",
                {bus_a.o_bus_addr, bus_a.o_bus_wdata, bus_a.o_bus_we, bus_a.o_bus_mask, bus_a.o_mem_data}); end
        total++; if (bus_b.o_err !== 1'b0) begin
            bad++; $display("FAIL rstmid_err_cleared got=%b exp=0", bus_b.o_err); end
        tick;
        bus_a.i_bus_ack = 1; bus_a.i_bus_rdata = 32'h5555_AAAA;
        tick;
        bus_a.i_bus_ack = 0;
        #1;
        total++; if ({bus_a.o_bus_req, bus_a.o_stall, bus_a.o_mem_data} !== {2'b00, 32'h0}) begin
            bad++; $display("FAIL rstmid_stray_ack got=%h exp=0", {bus_a.o_bus_req, bus_a.o_stall, bus_a.o_mem_data}); end
    endtask

    initial begin
        idle_inputs();
        test_reset();
        test_load_immediate();
        test_store_slow();
        test_zero_mask_store();
        test_ack_on_timeout();
        test_timeout();
        test_back_to_back();
        test_reset_mid();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
